// File: rtl/turbo_pkg.sv
// Shared types and constants for the de-interleaver PB buffer: PB size encodings,
// byte lengths, write-FSM states and the byte-stream beat payload.
package turbo_pkg;

  localparam int unsigned DW          = 8;
  localparam int unsigned MAX_BYTES   = 520;
  localparam int unsigned AW          = 10;
  localparam int unsigned PB16_BYTES  = 16;
  localparam int unsigned PB136_BYTES = 136;
  localparam int unsigned PB520_BYTES = 520;

  typedef enum logic [1:0] {
    PB16    = 2'd0,
    PB136   = 2'd1,
    PB520   = 2'd2,
    PB_RSVD = 2'd3
  } pb_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } pb_beat_t;

  // Byte length of a PB; the reserved code is rejected before this is used
  function automatic logic [AW-1:0] pb_len(input logic [1:0] size);
    case (size)
      2'd0:    pb_len = AW'(PB16_BYTES);
      2'd1:    pb_len = AW'(PB136_BYTES);
      default: pb_len = AW'(PB520_BYTES);
    endcase
  endfunction

endpackage

// File: rtl/deitl_pb_buffer_if.sv
// Bus bundle of the PB buffer: de-interleaver lanes and control in, byte stream
// and status pulses out. The buffer itself uses the slave view.
interface deitl_pb_buffer_if;
  import turbo_pkg::*;

  logic          start;
  logic [1:0]    pb_size;
  logic [1:0]    din0;
  logic [1:0]    din1;
  logic [1:0]    din2;
  logic [1:0]    din3;
  logic          din_vld;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          dout_last;
  logic          pb_done;
  logic          ovf_err;
  logic          prot_err;

  modport master (
    output start, pb_size, din0, din1, din2, din3, din_vld, dout_rdy,
    input  dout, dout_vld, dout_last, pb_done, ovf_err, prot_err
  );

  modport slave (
    input  start, pb_size, din0, din1, din2, din3, din_vld, dout_rdy,
    output dout, dout_vld, dout_last, pb_done, ovf_err, prot_err
  );

endinterface

// File: rtl/pb_bank_ram.sv
// Two-bank byte store: one write port, one registered read port.
// Address MSB selects the bank, the low AW bits the byte within it.
module pb_bank_ram
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2][MAX_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[AW]][raddr[AW-1:0]];
  end

endmodule

// File: rtl/deitl_pb_buffer.sv
// Ping-pong PB buffer: packs 4x2-bit de-interleaver lanes into bytes, fills one
// bank while the other drains to the turbo decoder as a valid/ready byte stream.
module deitl_pb_buffer
  import turbo_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  deitl_pb_buffer_if.slave  bus
);

  wr_state_e          state_q, state_d;
  logic               wbank_q, wbank_d;
  logic [AW-1:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]      wlen_q, wlen_d;
  logic               fill_done, wr_en, ovf_d, prot_d;
  logic               pb_done_q, ovf_q, prot_q;

  logic [1:0]         full_q;
  logic [1:0][AW-1:0] len_q;

  logic               rbank_q, rdone_q, rd_vld_q, rd_last_q;
  logic [AW-1:0]      rcnt_q;
  logic [DW-1:0]      rdata;
  pb_beat_t           ram_beat, out_q, skid_q;
  logic               out_vld_q, skid_vld_q;
  logic [1:0]         occ;
  logic               accept, drain_done, room, issue, rd_is_last;

  // Write FSM: next state and write-side pulses
  always_comb begin
    state_d   = state_q;
    wbank_d   = wbank_q;
    wcnt_d    = wcnt_q;
    wlen_d    = wlen_q;
    fill_done = 1'b0;
    wr_en     = 1'b0;
    ovf_d     = 1'b0;
    prot_d    = 1'b0;
    if (bus.start) begin
      if (pb_size_e'(bus.pb_size) == PB_RSVD) begin
        prot_d  = 1'b1;
        state_d = IDLE;
      end else if (full_q[wbank_q]) begin
        ovf_d   = 1'b1;
        state_d = DROP;
      end else begin
        state_d = FILL;
        wcnt_d  = '0;
        wlen_d  = pb_len(bus.pb_size);
      end
    end else if (bus.din_vld) begin
      unique case (state_q)
        FILL: begin
          wr_en = 1'b1;
          if (wcnt_q == wlen_q - AW'(1)) begin
            fill_done = 1'b1;
            wbank_d   = ~wbank_q;
            state_d   = IDLE;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
        IDLE:    prot_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      wbank_q   <= 1'b0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      pb_done_q <= 1'b0;
      ovf_q     <= 1'b0;
      prot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wbank_q   <= wbank_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      pb_done_q <= fill_done;
      ovf_q     <= ovf_d;
      prot_q    <= prot_d;
    end
  end

  // Bank ownership: fill and drain always target different banks
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full_q <= '0;
      len_q  <= '0;
    end else begin
      if (fill_done) begin
        full_q[wbank_q] <= 1'b1;
        len_q[wbank_q]  <= wlen_q;
      end
      if (drain_done) full_q[rbank_q] <= 1'b0;
    end
  end

  pb_bank_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wbank_q, wcnt_q}),
    .wdata ({bus.din3, bus.din2, bus.din1, bus.din0}),
    .re    (issue),
    .raddr ({rbank_q, rcnt_q}),
    .rdata (rdata)
  );

  // A read is issued only if its data will find a free slot in out/skid on arrival
  assign accept     = out_vld_q && bus.dout_rdy;
  assign drain_done = accept && out_q.last;
  assign occ        = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q);
  assign room       = (occ < 2'd2) || ((occ == 2'd2) && accept);
  assign issue      = full_q[rbank_q] && !rdone_q && room;
  assign rd_is_last = (rcnt_q == len_q[rbank_q] - AW'(1));
  assign ram_beat   = {rd_last_q, rdata};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rbank_q    <= 1'b0;
      rcnt_q     <= '0;
      rdone_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && rd_is_last;
      if (drain_done) begin
        rbank_q <= ~rbank_q;
        rdone_q <= 1'b0;
        rcnt_q  <= '0;
      end else if (issue) begin
        if (rd_is_last) rdone_q <= 1'b1;
        else            rcnt_q  <= rcnt_q + AW'(1);
      end
      if (!out_vld_q || accept) begin
        if (skid_vld_q) begin
          out_q      <= skid_q;
          out_vld_q  <= 1'b1;
          skid_q     <= ram_beat;
          skid_vld_q <= rd_vld_q;
        end else begin
          out_q      <= ram_beat;
          out_vld_q  <= rd_vld_q;
          skid_vld_q <= 1'b0;
        end
      end else if (rd_vld_q) begin
        skid_q     <= ram_beat;
        skid_vld_q <= 1'b1;
      end
    end
  end

  assign bus.dout      = out_q.data;
  assign bus.dout_vld  = out_vld_q;
  assign bus.dout_last = out_q.last;
  assign bus.pb_done   = pb_done_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.prot_err  = prot_q;

endmodule

// File: tb/tb_deitl_pb_buffer.sv
// Directed bench for deitl_pb_buffer: PB16 timing, lane packing, back-to-back PB520,
// overflow, abort/protocol errors and reset mid-drain.
module tb_deitl_pb_buffer;
  import turbo_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  deitl_pb_buffer_if bus ();

  deitl_pb_buffer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int rx_base = 0, exp_base = 0;
  int cnt_done = 0, cnt_ovf = 0, cnt_prot = 0, hold_err = 0;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bus.din0    = b[1:0];
    bus.din1    = b[3:2];
    bus.din2    = b[5:4];
    bus.din3    = b[7:6];
    bus.din_vld = 1'b1;
    tick();
    bus.din_vld = 1'b0;
  endtask

  task automatic send_pb(input int n, input logic [7:0] base, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + 8'(i));
      drive_byte(b);
      if (keep) begin
        exp_data.push_back(b);
        exp_last.push_back(i == n - 1);
      end
    end
  endtask

  task automatic do_start(input logic [1:0] sz);
    bus.start   = 1'b1;
    bus.pb_size = sz;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic mark();
    rx_base  = rx_data.size();
    exp_base = exp_data.size();
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int cyc = 0;
    while ((rx_data.size() - rx_base) < n && cyc < budget) begin
      tick();
      cyc++;
    end
    check({tag, "_in_time"}, 32'((rx_data.size() - rx_base) >= n), 1);
  endtask

  task automatic compare_rx(input string tag);
    int n     = exp_data.size() - exp_base;
    int got_n = rx_data.size() - rx_base;
    int derr  = 0;
    int lerr  = 0;
    check({tag, "_count"}, got_n, n);
    for (int k = 0; k < n; k++) begin
      if (k >= got_n) derr++;
      else begin
        if (rx_data[rx_base + k] !== exp_data[exp_base + k]) derr++;
        if (rx_last[rx_base + k] !== exp_last[exp_base + k]) lerr++;
      end
    end
    check({tag, "_data_errs"}, derr, 0);
    check({tag, "_last_errs"}, lerr, 0);
  endtask

  // Consumer ready: 0 = always ready, 1 = toggling, 2 = stalled
  initial begin
    bit ph;
    ph = 1'b0;
    bus.dout_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph = ~ph;
      case (rdy_mode)
        0:       bus.dout_rdy = 1'b1;
        1:       bus.dout_rdy = ph;
        default: bus.dout_rdy = 1'b0;
      endcase
    end
  end

  // Output monitor: accepted bytes, status pulses, hold-while-stalled
  initial begin
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) stall = 1'b0;
      else begin
        if (stall && (!bus.dout_vld || bus.dout !== held)) hold_err++;
        if (bus.dout_vld && bus.dout_rdy) begin
          rx_data.push_back(bus.dout);
          rx_last.push_back(bus.dout_last);
        end
        stall = bus.dout_vld && !bus.dout_rdy;
        held  = bus.dout;
        if (bus.pb_done)  cnt_done++;
        if (bus.ovf_err)  cnt_ovf++;
        if (bus.prot_err) cnt_prot++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, o0, p0, r0;
    n_rst       = 1'b0;
    bus.start   = 1'b0;
    bus.pb_size = 2'd0;
    bus.din0    = 2'd0;
    bus.din1    = 2'd0;
    bus.din2    = 2'd0;
    bus.din3    = 2'd0;
    bus.din_vld = 1'b0;
    repeat (3) tick();

    check("rst_dout_vld",  32'(bus.dout_vld),  0);
    check("rst_dout",      32'(bus.dout),      0);
    check("rst_dout_last", 32'(bus.dout_last), 0);
    check("rst_pb_done",   32'(bus.pb_done),   0);
    check("rst_ovf_err",   32'(bus.ovf_err),   0);
    check("rst_prot_err",  32'(bus.prot_err),  0);
    n_rst = 1'b1;
    tick();

    // PB16 basic with latency checks
    mark();
    do_start(2'd0);
    send_pb(16, 8'h00, 1'b1);
    check("pb16_done_pulse", 32'(bus.pb_done),  1);
    check("pb16_vld_at_full", 32'(bus.dout_vld), 0);
    tick();
    check("pb16_done_clear", 32'(bus.pb_done),  0);
    check("pb16_vld_full_p1", 32'(bus.dout_vld), 0);
    tick();
    check("pb16_vld_full_p2", 32'(bus.dout_vld), 1);
    check("pb16_first_byte",  32'(bus.dout),     0);
    wait_rx("pb16", 16, 200);
    compare_rx("pb16");

    // Lane packing
    mark();
    do_start(2'd0);
    bus.din3    = 2'b11;
    bus.din2    = 2'b00;
    bus.din1    = 2'b10;
    bus.din0    = 2'b01;
    bus.din_vld = 1'b1;
    tick();
    bus.din_vld = 1'b0;
    exp_data.push_back(8'hC9);
    exp_last.push_back(1'b0);
    send_pb(15, 8'h51, 1'b1);
    wait_rx("lane", 16, 200);
    check("lane_pack", 32'((rx_data.size() > rx_base) ? rx_data[rx_base] : 8'h00), 32'hC9);
    compare_rx("lane");

    // Back-to-back PB520 x3, toggling ready
    rdy_mode = 1;
    mark();
    d0 = cnt_done;
    o0 = cnt_ovf;
    do_start(2'd2);
    send_pb(520, 8'h00, 1'b1);
    do_start(2'd2);
    send_pb(520, 8'h35, 1'b1);
    wait_rx("b2b_drain1", 520, 4000);
    do_start(2'd2);
    send_pb(520, 8'h9A, 1'b1);
    wait_rx("b2b_all", 1560, 6000);
    repeat (10) tick();
    compare_rx("b2b");
    check("b2b_pb_done", cnt_done - d0, 3);
    check("b2b_no_ovf",  cnt_ovf - o0, 0);

    // Overflow with consumer stalled
    rdy_mode = 2;
    tick();
    mark();
    d0 = cnt_done;
    o0 = cnt_ovf;
    p0 = cnt_prot;
    do_start(2'd1);
    send_pb(136, 8'h10, 1'b1);
    do_start(2'd1);
    send_pb(136, 8'h80, 1'b1);
    do_start(2'd1);
    check("ovf_pulse", 32'(bus.ovf_err), 1);
    send_pb(136, 8'hEE, 1'b0);
    check("ovf_count",   cnt_ovf - o0, 1);
    check("ovf_no_prot", cnt_prot - p0, 0);
    check("ovf_pb_done", cnt_done - d0, 2);
    rdy_mode = 0;
    wait_rx("ovf", 272, 2000);
    repeat (20) tick();
    compare_rx("ovf");

    // Abort a PB520 fill with a PB16 start
    mark();
    d0 = cnt_done;
    o0 = cnt_ovf;
    p0 = cnt_prot;
    do_start(2'd2);
    send_pb(100, 8'h20, 1'b0);
    do_start(2'd0);
    send_pb(16, 8'h40, 1'b1);
    wait_rx("abort", 16, 200);
    repeat (10) tick();
    compare_rx("abort");
    check("abort_pb_done", cnt_done - d0, 1);
    check("abort_no_prot", cnt_prot - p0, 0);
    check("abort_no_ovf",  cnt_ovf - o0, 0);

    // Protocol errors
    d0 = cnt_done;
    p0 = cnt_prot;
    drive_byte(8'h5A);
    check("prot_din_idle", 32'(bus.prot_err), 1);
    tick();
    do_start(2'd3);
    check("prot_rsvd_size", 32'(bus.prot_err), 1);
    repeat (20) tick();
    check("prot_count",   cnt_prot - p0, 2);
    check("rsvd_no_done", cnt_done - d0, 0);

    // Reset in the middle of a PB136 drain
    mark();
    do_start(2'd1);
    send_pb(136, 8'h60, 1'b1);
    wait_rx("rst_pre", 60, 500);
    n_rst = 1'b0;
    #1;
    check("rst_mid_vld",     32'(bus.dout_vld), 0);
    check("rst_mid_pb_done", 32'(bus.pb_done),  0);
    repeat (2) tick();
    n_rst = 1'b1;
    r0 = rx_data.size();
    repeat (30) tick();
    check("rst_no_partial", rx_data.size() - r0, 0);
    mark();
    do_start(2'd0);
    send_pb(16, 8'hA0, 1'b1);
    wait_rx("post_rst", 16, 200);
    repeat (5) tick();
    compare_rx("post_rst");

    check("hold_stable", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
